// File: rtl/sad_block_loader_if.sv
// Row-beat input and parallel block output bundle
// for the SAD source-side loader.
interface sad_block_loader_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sob;
  logic [8*WIDTH-1:0]     in_ori_row;
  logic [8*WIDTH-1:0]     in_can_row;
  logic                   blk_en;
  logic [32*WIDTH-1:0]    blk_ori;
  logic [32*WIDTH-1:0]    blk_can;
  logic [IDX_W-1:0]       blk_idx;
  logic                   err_drop;
  logic [7:0]             drop_cnt;

  modport master (
    output in_valid, in_sob,
    output in_ori_row, in_can_row,
    input  in_ready,
    input  blk_en, blk_ori, blk_can,
    input  blk_idx, err_drop, drop_cnt
  );

  modport slave (
    input  in_valid, in_sob,
    input  in_ori_row, in_can_row,
    output in_ready,
    output blk_en, blk_ori, blk_can,
    output blk_idx, err_drop, drop_cnt
  );
endinterface

// File: rtl/sad_block_loader.sv
// Assembles row-serial 4x8 ori/can beats into a
// parallel block with a one-cycle enable pulse.
module sad_block_loader #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  sad_block_loader_if.slave s_bus
);
  localparam int RW = 8 * WIDTH;

  logic [1:0]          r_rcnt;
  logic [RW-1:0]       r_ori0, r_ori1, r_ori2;
  logic [RW-1:0]       r_can0, r_can1, r_can2;
  logic                r_blk_en;
  logic                r_err_drop;
  logic [7:0]          r_drop_cnt;
  logic [4*RW-1:0]     r_blk_ori;
  logic [4*RW-1:0]     r_blk_can;
  logic [IDX_W-1:0]    r_blk_idx;

  logic                w_acc;
  logic [1:0]          w_row;
  logic                w_drop;
  logic                w_done;

  // No backpressure: ready whenever not in reset.
  assign s_bus.in_ready = ~rst;

  assign w_acc  = s_bus.in_valid & ~rst;
  assign w_row  = s_bus.in_sob ? 2'd0 : r_rcnt;
  assign w_drop = w_acc & s_bus.in_sob
                & (r_rcnt != 2'd0);
  assign w_done = w_acc & (w_row == 2'd3);

  // Row counter and assembly buffers for rows 0..2;
  // row 3 is taken straight from the completing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= 2'd0;
      r_ori0 <= '0;
      r_ori1 <= '0;
      r_ori2 <= '0;
      r_can0 <= '0;
      r_can1 <= '0;
      r_can2 <= '0;
    end else if (w_acc) begin
      r_rcnt <= w_row + 2'd1;
      unique case (w_row)
        2'd0: begin
          r_ori0 <= s_bus.in_ori_row;
          r_can0 <= s_bus.in_can_row;
        end
        2'd1: begin
          r_ori1 <= s_bus.in_ori_row;
          r_can1 <= s_bus.in_can_row;
        end
        2'd2: begin
          r_ori2 <= s_bus.in_ori_row;
          r_can2 <= s_bus.in_can_row;
        end
        default: ;
      endcase
    end
  end

  // Block outputs, index, and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_en   <= 1'b0;
      r_err_drop <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_blk_ori  <= '0;
      r_blk_can  <= '0;
      r_blk_idx  <= '0;
    end else begin
      r_blk_en   <= w_done;
      r_err_drop <= w_drop;
      if (w_drop && r_drop_cnt != 8'hff)
        r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_done) begin
        r_blk_ori <= {s_bus.in_ori_row,
                      r_ori2, r_ori1, r_ori0};
        r_blk_can <= {s_bus.in_can_row,
                      r_can2, r_can1, r_can0};
        r_blk_idx <= r_blk_idx + 1'b1;
      end
    end
  end

  assign s_bus.blk_en   = r_blk_en;
  assign s_bus.blk_ori  = r_blk_ori;
  assign s_bus.blk_can  = r_blk_can;
  assign s_bus.blk_idx  = r_blk_idx;
  assign s_bus.err_drop = r_err_drop;
  assign s_bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_sad_block_loader.sv
// Directed bench for sad_block_loader, with a second
// instance at IDX_W=2 to exercise index wrap.
module tb_sad_block_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v   = 1'b0;
  logic sob = 1'b0;
  logic [63:0] ori = '0;
  logic [63:0] can = '0;

  int nchk = 0;
  int nbad = 0;
  int exp_idx = 0;

  always #5 clk = ~clk;

  sad_block_loader_if #(.WIDTH(8), .IDX_W(10)) u_if ();
  sad_block_loader_if #(.WIDTH(8), .IDX_W(2))  u_if2 ();

  assign u_if.in_valid    = v;
  assign u_if.in_sob      = sob;
  assign u_if.in_ori_row  = ori;
  assign u_if.in_can_row  = can;
  assign u_if2.in_valid   = v;
  assign u_if2.in_sob     = sob;
  assign u_if2.in_ori_row = ori;
  assign u_if2.in_can_row = can;

  sad_block_loader #(.WIDTH(8), .IDX_W(10)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (u_if.slave)
  );

  sad_block_loader #(.WIDTH(8), .IDX_W(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .s_bus (u_if2.slave)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] orow(int b, int r);
    logic [63:0] x;
    for (int c = 0; c < 8; c++)
      x[c*8 +: 8] = 8'(b*32 + r*8 + c);
    return x;
  endfunction

  function automatic logic [63:0] crow(int b, int r);
    logic [63:0] x;
    for (int c = 0; c < 8; c++)
      x[c*8 +: 8] = 8'(b*32 + 31 - (r*8 + c));
    return x;
  endfunction

  function automatic logic [255:0] oblk(int b);
    logic [255:0] x;
    for (int i = 0; i < 32; i++)
      x[i*8 +: 8] = 8'(b*32 + i);
    return x;
  endfunction

  function automatic logic [255:0] cblk(int b);
    logic [255:0] x;
    for (int i = 0; i < 32; i++)
      x[i*8 +: 8] = 8'(b*32 + 31 - i);
    return x;
  endfunction

  // One clock: drive at negedge, check at next negedge.
  task automatic cyc(input logic iv, input logic is,
                     input logic [63:0] o,
                     input logic [63:0] c,
                     input logic ee, input logic ed);
    v = iv; sob = is; ori = o; can = c;
    @(posedge clk);
    @(negedge clk);
    chk("blk_en", 256'(u_if.blk_en), 256'(ee));
    chk("err_drop", 256'(u_if.err_drop), 256'(ed));
  endtask

  task automatic send_blk(input int b, input logic d0);
    for (int r = 0; r < 4; r++)
      cyc(1'b1, r == 0, orow(b, r), crow(b, r),
          r == 3, (r == 0) ? d0 : 1'b0);
    exp_idx++;
    chk("blk_ori", u_if.blk_ori, oblk(b));
    chk("blk_can", u_if.blk_can, cblk(b));
    chk("blk_idx", 256'(u_if.blk_idx),
        256'(exp_idx % 1024));
    chk("blk_idx2", 256'(u_if2.blk_idx),
        256'(exp_idx % 4));
  endtask

  task automatic do_reset();
    rst = 1'b1; v = 1'b0; sob = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_en", 256'(u_if.blk_en), 256'(0));
    chk("rst_ori", u_if.blk_ori, 256'(0));
    chk("rst_can", u_if.blk_can, 256'(0));
    chk("rst_idx", 256'(u_if.blk_idx), 256'(0));
    chk("rst_drop", 256'(u_if.err_drop), 256'(0));
    chk("rst_dcnt", 256'(u_if.drop_cnt), 256'(0));
    chk("rst_rdy", 256'(u_if.in_ready), 256'(0));
    rst = 1'b0;
    exp_idx = 0;
    #1;
    chk("rdy", 256'(u_if.in_ready), 256'(1));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // single block, pixel i = i / 31-i
    send_blk(0, 1'b0);
    cyc(1'b0, 1'b0, 64'hdead, 64'hbeef, 1'b0, 1'b0);
    chk("hold_ori", u_if.blk_ori, oblk(0));

    // three back-to-back blocks
    do_reset();
    send_blk(1, 1'b0);
    send_blk(2, 1'b0);
    send_blk(3, 1'b0);

    // truncated block then a full one
    cyc(1'b1, 1'b1, orow(5, 0), crow(5, 0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, orow(5, 1), crow(5, 1), 1'b0, 1'b0);
    send_blk(6, 1'b1);
    chk("dcnt1", 256'(u_if.drop_cnt), 256'(1));

    // valid toggling with garbage in idle cycles
    for (int r = 0; r < 4; r++) begin
      cyc(1'b1, r == 0, orow(4, r), crow(4, r),
          r == 3, 1'b0);
      if (r < 3)
        cyc(1'b0, 1'b1, {$urandom, $urandom},
            {$urandom, $urandom}, 1'b0, 1'b0);
    end
    chk("tog_ori", u_if.blk_ori, oblk(4));
    chk("tog_can", u_if.blk_can, cblk(4));
    chk("tog_idx", 256'(u_if.blk_idx), 256'(5));

    // reset after three rows
    for (int r = 0; r < 3; r++)
      cyc(1'b1, r == 0, orow(7, r), crow(7, r),
          1'b0, 1'b0);
    do_reset();
    send_blk(8, 1'b0);
    chk("dcnt0", 256'(u_if.drop_cnt), 256'(0));

    // drop saturation and index wrap
    do_reset();
    cyc(1'b1, 1'b1, orow(1, 0), crow(1, 0), 1'b0, 1'b0);
    for (int k = 0; k < 300; k++)
      cyc(1'b1, 1'b1, orow(1, 0), crow(1, 0),
          1'b0, 1'b1);
    chk("dcnt_sat", 256'(u_if.drop_cnt), 256'(255));
    for (int k = 0; k < 5; k++)
      send_blk(k, k == 0);
    chk("dcnt_hold", 256'(u_if.drop_cnt), 256'(255));
    chk("idx2_end", 256'(u_if2.blk_idx), 256'(1));

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
